// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the three-port SRAM arbiter: FSM encoding,
// requester IDs and the wait-state limit.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] ID_INSTR = 2'd0;
    localparam logic [1:0] ID_DATA  = 2'd1;
    localparam logic [1:0] ID_JTAG  = 2'd2;

    // Round-robin memory of which core port was granted last.
    localparam logic LG_INSTR = 1'b0;
    localparam logic LG_DATA  = 1'b1;

    localparam int WAIT_CYCLES_MAX = 7;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: JTAG (only while paused) first, then
// instr/data round-robin on the last-grant bit.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       jtag_req,
    input  logic       instr_req,
    input  logic       data_req,
    input  logic       is_paused,
    input  logic       last_grant,
    output logic [1:0] winner_id,
    output logic       valid
);

    always_comb begin
        winner_id = ID_INSTR;
        valid     = 1'b0;
        if (jtag_req && is_paused) begin
            winner_id = ID_JTAG;
            valid     = 1'b1;
        end else if (instr_req && data_req) begin
            winner_id = (last_grant == LG_INSTR) ? ID_DATA : ID_INSTR;
            valid     = 1'b1;
        end else if (instr_req) begin
            winner_id = ID_INSTR;
            valid     = 1'b1;
        end else if (data_req) begin
            winner_id = ID_DATA;
            valid     = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter for JTAG, instruction and data requesters.
// IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE (ack pulse) -> IDLE.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_isPaused,
    input  logic        i_jtagReq,
    input  logic        i_instrReq,
    input  logic        i_dataReq,
    input  logic [15:0] i_jtagAddr,
    input  logic [15:0] i_instrAddr,
    input  logic [15:0] i_dataAddr,
    input  logic        i_jtagWr,
    input  logic        i_dataWr,
    input  logic [15:0] i_jtagData,
    input  logic [15:0] i_dataData,
    output logic        o_jtagAck,
    output logic        o_instrAck,
    output logic        o_dataAck,
    output logic [15:0] o_rdData,
    output logic [15:0] o_memAddr,
    output logic        o_memWr,
    output logic        o_memEn,
    output logic [15:0] o_memDataOut,
    output logic        o_memDrive,
    input  logic [15:0] i_memData,
    output logic        o_busy,
    output logic [1:0]  o_dbgState
);

    localparam logic [2:0] WAIT_LAST =
        3'((WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]  winner_q, winner_d;
    logic [15:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        last_grant_q, last_grant_d;

    logic [1:0]  pick_id;
    logic        pick_valid;

    mem_arb_pick u_pick (
        .jtag_req   (i_jtagReq),
        .instr_req  (i_instrReq),
        .data_req   (i_dataReq),
        .is_paused  (i_isPaused),
        .last_grant (last_grant_q),
        .winner_id  (pick_id),
        .valid      (pick_valid)
    );

    // Req/ack handshake: a request is sampled only on an edge where the FSM
    // is IDLE; once latched the access always runs to completion and the
    // winner sees exactly one ack pulse in DONE, whatever its request does.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        winner_d     = winner_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        rd_data_d    = rd_data_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    winner_d   = pick_id;
                    wait_cnt_d = 3'd0;
                    state_d    = ST_ACCESS;
                    case (pick_id)
                        ID_JTAG: begin
                            addr_d  = i_jtagAddr;
                            wr_d    = i_jtagWr;
                            wdata_d = i_jtagData;
                        end
                        ID_DATA: begin
                            addr_d       = i_dataAddr;
                            wr_d         = i_dataWr;
                            wdata_d      = i_dataData;
                            last_grant_d = LG_DATA;
                        end
                        default: begin
                            addr_d       = i_instrAddr;
                            wr_d         = 1'b0;
                            wdata_d      = 16'h0000;
                            last_grant_d = LG_INSTR;
                        end
                    endcase
                end
            end
            ST_ACCESS: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_DONE;
                    if (!wr_q) begin
                        rd_data_d = i_memData;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= 3'd0;
            winner_q     <= ID_INSTR;
            addr_q       <= 16'h0000;
            wr_q         <= 1'b0;
            wdata_q      <= 16'h0000;
            rd_data_q    <= 16'h0000;
            last_grant_q <= LG_INSTR;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            winner_q     <= winner_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            rd_data_q    <= rd_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Outputs decode straight from flops so an async reset clears them at once.
    always_comb begin
        o_memEn      = (state_q == ST_ACCESS);
        o_memWr      = o_memEn && wr_q;
        o_memDrive   = o_memEn && wr_q;
        o_memDataOut = o_memDrive ? wdata_q : 16'h0000;
        o_memAddr    = addr_q;
        o_jtagAck    = (state_q == ST_DONE) && (winner_q == ID_JTAG);
        o_instrAck   = (state_q == ST_DONE) && (winner_q == ID_INSTR);
        o_dataAck    = (state_q == ST_DONE) && (winner_q == ID_DATA);
        o_rdData     = rd_data_q;
        o_busy       = (state_q != ST_IDLE);
        o_dbgState   = state_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter (WAIT_CYCLES=1) with a
// transaction-level reference model feeding a cycle-checking scoreboard.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int W = 1;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_isPaused = 1'b0;
    logic        i_jtagReq = 1'b0, i_instrReq = 1'b0, i_dataReq = 1'b0;
    logic [15:0] i_jtagAddr = '0, i_instrAddr = '0, i_dataAddr = '0;
    logic        i_jtagWr = 1'b0, i_dataWr = 1'b0;
    logic [15:0] i_jtagData = '0, i_dataData = '0;
    logic [15:0] i_memData = '0;
    logic        o_jtagAck, o_instrAck, o_dataAck;
    logic [15:0] o_rdData, o_memAddr, o_memDataOut;
    logic        o_memWr, o_memEn, o_memDrive, o_busy;
    logic [1:0]  o_dbgState;

    mem_arbiter #(.WAIT_CYCLES(W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_isPaused(i_isPaused),
        .i_jtagReq(i_jtagReq), .i_instrReq(i_instrReq), .i_dataReq(i_dataReq),
        .i_jtagAddr(i_jtagAddr), .i_instrAddr(i_instrAddr), .i_dataAddr(i_dataAddr),
        .i_jtagWr(i_jtagWr), .i_dataWr(i_dataWr),
        .i_jtagData(i_jtagData), .i_dataData(i_dataData),
        .o_jtagAck(o_jtagAck), .o_instrAck(o_instrAck), .o_dataAck(o_dataAck),
        .o_rdData(o_rdData), .o_memAddr(o_memAddr), .o_memWr(o_memWr),
        .o_memEn(o_memEn), .o_memDataOut(o_memDataOut), .o_memDrive(o_memDrive),
        .i_memData(i_memData), .o_busy(o_busy), .o_dbgState(o_dbgState)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 i_clk = ~i_clk;
    int cyc = 0;
    always @(posedge i_clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Unwritten SRAM words hold an address-derived pattern; 0x1234 holds 0xBEEF.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h1234) ? 16'hBEEF : 16'(a * 16'd7 + 16'd3);
    endfunction

    // ---------------- SRAM model (driven from the DUT's bus) ----------------
    logic [15:0] sram [int];
    always @(negedge i_clk) begin
        if (o_memEn && o_memWr && o_memDrive) sram[int'(o_memAddr)] = o_memDataOut;
        if (o_memEn && !o_memWr)
            i_memData = sram.exists(int'(o_memAddr)) ? sram[int'(o_memAddr)] : init_val(o_memAddr);
        else
            i_memData = 16'hDEAD;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0]  id;
        logic [15:0] addr;
        logic        wr;
        logic [15:0] wdata;
        logic [15:0] rd;
        int          s;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] ref_mem [int];
    logic [1:0]  m_last = ID_INSTR;
    logic [15:0] m_rd = 16'h0000;
    int          next_sample = 0;

    // Called with the inputs that the next rising edge will sample.
    task automatic model_eval();
        exp_t e;
        logic jel;
        int   s;
        s   = cyc + 1;
        jel = i_jtagReq && i_isPaused;
        if (s < next_sample || !(jel || i_instrReq || i_dataReq)) return;
        if (jel) e.id = ID_JTAG;
        else if (i_instrReq && i_dataReq) e.id = (m_last == ID_INSTR) ? ID_DATA : ID_INSTR;
        else if (i_instrReq) e.id = ID_INSTR;
        else e.id = ID_DATA;
        if (e.id != ID_JTAG) m_last = e.id;
        if (e.id == ID_JTAG) begin
            e.addr = i_jtagAddr; e.wr = i_jtagWr; e.wdata = i_jtagData;
        end else if (e.id == ID_DATA) begin
            e.addr = i_dataAddr; e.wr = i_dataWr; e.wdata = i_dataData;
        end else begin
            e.addr = i_instrAddr; e.wr = 1'b0; e.wdata = 16'h0000;
        end
        if (e.wr) begin
            ref_mem[int'(e.addr)] = e.wdata;
            e.rd = m_rd;
        end else begin
            e.rd = ref_mem.exists(int'(e.addr)) ? ref_mem[int'(e.addr)] : init_val(e.addr);
            m_rd = e.rd;
        end
        e.s = s;
        exp_q.push_back(e);
        // ACCESS + DONE + one IDLE cycle before the next sampling edge.
        next_sample = s + W + 3;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last      = ID_INSTR;
        m_rd        = 16'h0000;
        next_sample = 0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic       mon_en = 1'b0;
    exp_t       mon_e;
    logic [1:0] ack_ids[$];
    int         ack_cyc[$];

    always @(negedge i_clk) begin
        if (mon_en) begin
            if (exp_q.size() != 0 && cyc >= exp_q[0].s) begin
                mon_e = exp_q[0];
                if (cyc <= mon_e.s + W) begin
                    chk("access_bus",
                        64'({o_busy, o_memEn, o_memWr, o_memDrive, o_memAddr,
                             (mon_e.wr ? o_memDataOut : 16'h0000), o_jtagAck, o_instrAck, o_dataAck}),
                        64'({1'b1, 1'b1, mon_e.wr, mon_e.wr, mon_e.addr,
                             (mon_e.wr ? mon_e.wdata : 16'h0000), 3'b000}));
                end else begin
                    chk("done_ack",
                        64'({o_busy, o_memEn, o_memWr, o_memDrive, o_jtagAck, o_instrAck, o_dataAck, o_rdData}),
                        64'({4'b1000, mon_e.id == ID_JTAG, mon_e.id == ID_INSTR, mon_e.id == ID_DATA, mon_e.rd}));
                    ack_ids.push_back(o_jtagAck ? ID_JTAG : o_dataAck ? ID_DATA : o_instrAck ? ID_INSTR : 2'd3);
                    ack_cyc.push_back(cyc);
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_bus",
                    64'({o_busy, o_memEn, o_memWr, o_memDrive, o_jtagAck, o_instrAck, o_dataAck}), 64'(0));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        i_isPaused = 1'b0;
        i_jtagReq = 1'b0; i_instrReq = 1'b0; i_dataReq = 1'b0;
        i_jtagAddr = '0; i_instrAddr = '0; i_dataAddr = '0;
        i_jtagWr = 1'b0; i_dataWr = 1'b0; i_jtagData = '0; i_dataData = '0;
    endtask

    task automatic step();
        model_eval();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain(input int n);
        clear_inputs();
        repeat (n) step();
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        mon_en = 1'b0;
        i_rst  = 1'b1;
        i_jtagReq = 1'b1; i_instrReq = 1'b1; i_dataReq = 1'b1; i_isPaused = 1'b1;
        #1;
        chk("reset_outputs",
            64'({o_jtagAck, o_instrAck, o_dataAck, o_rdData, o_memAddr, o_memWr, o_memEn,
                 o_memDataOut, o_memDrive, o_busy, o_dbgState}), 64'(0));
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_hold",
            64'({o_jtagAck, o_instrAck, o_dataAck, o_rdData, o_memEn, o_memDrive, o_busy, o_dbgState}), 64'(0));
        model_reset();
        clear_inputs();
        i_rst  = 1'b0;
        mon_en = 1'b1;
    endtask

    logic [1:0] rr_exp [4];

    // ---------------- stimulus ----------------
    initial begin
        rr_exp = '{ID_DATA, ID_INSTR, ID_DATA, ID_INSTR};
        do_reset();

        // Instruction read of 0x1234.
        ack_ids.delete();
        i_instrReq = 1'b1; i_instrAddr = 16'h1234;
        step();
        drain(6);
        chk("instr_read_ack", 64'(ack_ids.size() > 0 ? ack_ids[0] : 2'd3), 64'(ID_INSTR));
        chk("instr_read_data", 64'(o_rdData), 64'(16'hBEEF));

        // JTAG write of 0xA5A5 to 0x00FF; read data must not move.
        ack_ids.delete();
        i_isPaused = 1'b1; i_jtagReq = 1'b1; i_jtagWr = 1'b1;
        i_jtagAddr = 16'h00FF; i_jtagData = 16'hA5A5;
        step();
        drain(6);
        chk("jtag_write_ack", 64'(ack_ids.size() > 0 ? ack_ids[0] : 2'd3), 64'(ID_JTAG));
        chk("jtag_write_rd_hold", 64'(o_rdData), 64'(16'hBEEF));

        // JTAG read while not paused is ignored, then wins once paused.
        ack_ids.delete();
        i_jtagReq = 1'b1; i_jtagAddr = 16'h00FF;
        repeat (20) step();
        chk("unpaused_jtag_ignored", 64'(ack_ids.size()), 64'(0));
        i_isPaused = 1'b1; i_instrReq = 1'b1; i_instrAddr = 16'h0003;
        step();
        i_jtagReq = 1'b0;
        repeat (5) step();
        drain(6);
        chk("paused_jtag_first", 64'(ack_ids.size() > 0 ? ack_ids[0] : 2'd3), 64'(ID_JTAG));
        chk("paused_instr_second", 64'(ack_ids.size() > 1 ? ack_ids[1] : 2'd3), 64'(ID_INSTR));
        chk("paused_jtag_read_data", 64'(o_rdData), 64'(init_val(16'h0003)));

        // Instr and data held from reset: round-robin, data first.
        do_reset();
        ack_ids.delete(); ack_cyc.delete();
        i_instrReq = 1'b1; i_instrAddr = 16'h0005;
        i_dataReq = 1'b1; i_dataAddr = 16'h0006;
        repeat (13) step();
        drain(8);
        chk("rr_grant_count", 64'(ack_ids.size() >= 4), 64'(1));
        if (ack_ids.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("rr_order", 64'(ack_ids[i]), 64'(rr_exp[i]));
            for (int i = 0; i < 3; i++) chk("rr_spacing", 64'(ack_cyc[i+1] - ack_cyc[i]), 64'(W + 3));
        end

        // Reset in the second ACCESS cycle of a data write.
        do_reset();
        i_dataReq = 1'b1; i_dataWr = 1'b1; i_dataAddr = 16'h0010; i_dataData = 16'h1111;
        step();
        clear_inputs();
        @(posedge i_clk);
        #1;
        chk("mid_access_active", 64'({o_memEn, o_memDrive}), 64'(2'b11));
        mon_en = 1'b0;
        i_rst  = 1'b1;
        #1;
        chk("mid_access_reset_drop",
            64'({o_memEn, o_memDrive, o_memWr, o_jtagAck, o_instrAck, o_dataAck, o_busy}), 64'(0));
        repeat (2) @(posedge i_clk);
        #1;
        model_reset();
        i_rst  = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("post_reset_idle", 64'({o_dbgState, o_busy}), 64'({ST_IDLE, 1'b0}));
        drain(4);

        // Random traffic; inputs change every cycle, including mid-access.
        for (int n = 0; n < 300; n++) begin
            i_jtagReq   = ($urandom_range(0, 3) == 0);
            i_isPaused  = 1'($urandom_range(0, 1));
            i_instrReq  = 1'($urandom_range(0, 1));
            i_dataReq   = 1'($urandom_range(0, 1));
            i_jtagAddr  = 16'($urandom_range(0, 15));
            i_instrAddr = 16'($urandom_range(0, 15));
            i_dataAddr  = 16'($urandom_range(0, 15));
            i_jtagWr    = 1'($urandom_range(0, 1));
            i_dataWr    = 1'($urandom_range(0, 1));
            i_jtagData  = 16'($urandom);
            i_dataData  = 16'($urandom);
            step();
        end
        drain(8);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
